// File: rtl/svm_seq_driver_if.sv
// Sample and result valid/ready streams between the
// sample source/result sink and the SVM sequence driver.
interface svm_seq_driver_if #(
    parameter int SAMPLE_W   = 44,
    parameter int CLASS_BITS = 3
);
    logic                  s_valid;
    logic                  s_ready;
    logic [SAMPLE_W-1:0]   s_sample;
    logic [CLASS_BITS-1:0] s_label;

    logic                  r_valid;
    logic                  r_ready;
    logic [CLASS_BITS-1:0] r_class;
    logic [CLASS_BITS-1:0] r_label;
    logic                  r_match;
    logic                  r_timeout;

    modport master (
        output s_valid, s_sample, s_label, r_ready,
        input  s_ready, r_valid, r_class, r_label,
        input  r_match, r_timeout
    );

    modport slave (
        input  s_valid, s_sample, s_label, r_ready,
        output s_ready, r_valid, r_class, r_label,
        output r_match, r_timeout
    );
endinterface

// File: rtl/svm_seq_driver.sv
// Sequencer feeding labelled samples to the sequential SVM classifier,
// restarting it per sample and reporting prediction, verdict and accuracy.
module svm_seq_driver #(
    parameter int N_FEATURES   = 11,
    parameter int FEATURE_BITS = 4,
    parameter int CLASS_BITS   = 3,
    parameter int CNT_WIDTH    = 16,
    parameter int TIMEOUT      = 1023
) (
    input  logic                                 clk,
    input  logic                                 rst,
    svm_seq_driver_if.slave                      bus,
    input  logic                                 clr_cnt,
    output logic [N_FEATURES*FEATURE_BITS-1:0]   clf_in,
    output logic                                 clf_rst_n,
    input  logic                                 clf_ready,
    input  logic [CLASS_BITS-1:0]                clf_class,
    output logic [CNT_WIDTH-1:0]                 total_cnt,
    output logic [CNT_WIDTH-1:0]                 correct_cnt,
    output logic                                 busy
);
    localparam int SW   = N_FEATURES * FEATURE_BITS;
    localparam int TO_W = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RESTART, RUN, RESULT} state_e;

    state_e                state_q, state_d;
    logic [SW-1:0]         clf_in_q, clf_in_d;
    logic [CLASS_BITS-1:0] label_q, label_d;
    logic [CLASS_BITS-1:0] cls_q, cls_d;
    logic                  match_q, match_d;
    logic                  tmo_q, tmo_d;
    logic [TO_W-1:0]       tcnt_q, tcnt_d;
    logic                  rdy_q, rdy_d;
    logic                  rstn_q, rstn_d;
    logic [CNT_WIDTH-1:0]  total_q, total_d;
    logic [CNT_WIDTH-1:0]  correct_q, correct_d;
    logic                  rise;
    logic                  capture;
    logic                  hit;

    assign rise = clf_ready & ~rdy_q;

    always_comb begin
        state_d   = state_q;
        clf_in_d  = clf_in_q;
        label_d   = label_q;
        cls_d     = cls_q;
        match_d   = match_q;
        tmo_d     = tmo_q;
        tcnt_d    = tcnt_q;
        rdy_d     = rdy_q;
        total_d   = total_q;
        correct_d = correct_q;
        capture   = 1'b0;
        hit       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.s_valid) begin
                    clf_in_d = bus.s_sample;
                    label_d  = bus.s_label;
                    state_d  = RESTART;
                end
            end
            RESTART: begin
                tcnt_d  = '0;
                rdy_d   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                rdy_d  = clf_ready;
                tcnt_d = tcnt_q + 1'b1;
                // a genuine edge beats a timeout landing on the same cycle
                if (rise) begin
                    hit     = (clf_class == label_q);
                    cls_d   = clf_class;
                    tmo_d   = 1'b0;
                    match_d = hit;
                    capture = 1'b1;
                    state_d = RESULT;
                end else if (tcnt_q == TO_LAST) begin
                    cls_d   = '0;
                    tmo_d   = 1'b1;
                    match_d = 1'b0;
                    capture = 1'b1;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (bus.r_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            if (clr_cnt) begin
                total_d   = CNT_WIDTH'(1);
                correct_d = CNT_WIDTH'(hit);
            end else begin
                if (total_q != '1) total_d = total_q + 1'b1;
                if (hit && correct_q != '1)
                    correct_d = correct_q + 1'b1;
            end
        end else if (clr_cnt) begin
            total_d   = '0;
            correct_d = '0;
        end

        rstn_d = (state_d == RUN) || (state_d == RESULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clf_in_q  <= '0;
            label_q   <= '0;
            cls_q     <= '0;
            match_q   <= 1'b0;
            tmo_q     <= 1'b0;
            tcnt_q    <= '0;
            rdy_q     <= 1'b0;
            rstn_q    <= 1'b0;
            total_q   <= '0;
            correct_q <= '0;
        end else begin
            state_q   <= state_d;
            clf_in_q  <= clf_in_d;
            label_q   <= label_d;
            cls_q     <= cls_d;
            match_q   <= match_d;
            tmo_q     <= tmo_d;
            tcnt_q    <= tcnt_d;
            rdy_q     <= rdy_d;
            rstn_q    <= rstn_d;
            total_q   <= total_d;
            correct_q <= correct_d;
        end
    end

    assign bus.s_ready   = (state_q == IDLE) & ~rst;
    assign bus.r_valid   = (state_q == RESULT);
    assign bus.r_class   = cls_q;
    assign bus.r_label   = label_q;
    assign bus.r_match   = match_q;
    assign bus.r_timeout = tmo_q;
    assign clf_in        = clf_in_q;
    assign clf_rst_n     = rstn_q;
    assign total_cnt     = total_q;
    assign correct_cnt   = correct_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_svm_seq_driver.sv
// Randomised and directed bench for svm_seq_driver against a
// transaction-level reference of latency, verdict and accuracy counters.
module tb_svm_seq_driver;
    localparam int TMO  = 31;
    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          clr_cnt;
    logic [43:0]   clf_in;
    logic          clf_rst_n;
    logic          clf_ready;
    logic [2:0]    clf_class;
    logic [CW-1:0] total_cnt;
    logic [CW-1:0] correct_cnt;
    logic          busy;

    int n_chk;
    int n_fail;
    int m_total;
    int m_correct;

    // behavioural classifier: ready rises lat cycles after release
    int         lat;
    logic [2:0] cls;
    int         ccnt;

    svm_seq_driver_if #(.SAMPLE_W(44), .CLASS_BITS(3)) bus ();

    svm_seq_driver #(
        .N_FEATURES  (11),
        .FEATURE_BITS(4),
        .CLASS_BITS  (3),
        .CNT_WIDTH   (CW),
        .TIMEOUT     (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .clr_cnt    (clr_cnt),
        .clf_in     (clf_in),
        .clf_rst_n  (clf_rst_n),
        .clf_ready  (clf_ready),
        .clf_class  (clf_class),
        .total_cnt  (total_cnt),
        .correct_cnt(correct_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!clf_rst_n) ccnt <= 0;
        else if (ccnt < 100000) ccnt <= ccnt + 1;
    end

    assign clf_ready = clf_rst_n && (ccnt >= lat);
    assign clf_class = cls;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [2:0] ecls,
                                input logic [2:0] elab, input bit emat,
                                input bit eto);
        check({tag, "_r_valid"}, bus.r_valid, 1);
        check({tag, "_r_class"}, bus.r_class, ecls);
        check({tag, "_r_label"}, bus.r_label, elab);
        check({tag, "_r_match"}, bus.r_match, emat);
        check({tag, "_r_timeout"}, bus.r_timeout, eto);
        check({tag, "_total"}, total_cnt, m_total);
        check({tag, "_correct"}, correct_cnt, m_correct);
        check({tag, "_s_ready"}, bus.s_ready, 0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge
    // following the result handshake.
    task automatic run(input string tag, input logic [43:0] smp,
                       input logic [2:0] lab, input int l,
                       input logic [2:0] c, input int bp,
                       input bit hold, input bit clr);
        bit         to;
        int         exp_lat;
        int         cyc;
        logic [2:0] ecls;
        bit         emat;
        to      = (l > TMO - 1);
        exp_lat = to ? 2 + TMO : 3 + l;
        ecls    = to ? 3'd0 : c;
        emat    = !to && (c == lab);
        lat          = l;
        cls          = c;
        bus.s_valid  = 1'b1;
        bus.s_sample = smp;
        bus.s_label  = lab;
        check({tag, "_s_ready_idle"}, bus.s_ready, 1);
        @(negedge clk);
        cyc = 1;
        if (!hold) bus.s_valid = 1'b0;
        check({tag, "_clf_rst_n_low"}, clf_rst_n, 0);
        check({tag, "_clf_in"}, clf_in, smp);
        check({tag, "_busy"}, busy, 1);
        @(negedge clk);
        cyc = 2;
        check({tag, "_clf_rst_n_high"}, clf_rst_n, 1);
        while (!bus.r_valid && cyc < 80) begin
            clr_cnt = clr && (cyc == exp_lat - 1);
            @(negedge clk);
            cyc++;
        end
        clr_cnt = 1'b0;
        check({tag, "_latency"}, cyc, exp_lat);
        if (clr) begin
            m_total   = 1;
            m_correct = emat ? 1 : 0;
        end else begin
            if (m_total < MAXC) m_total++;
            if (emat && m_correct < MAXC) m_correct++;
        end
        check_result(tag, ecls, lab, emat, to);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check_result({tag, "_bp"}, ecls, lab, emat, to);
        end
        bus.r_ready = 1'b1;
        @(negedge clk);
        bus.r_ready = 1'b0;
        check({tag, "_s_ready_after"}, bus.s_ready, 1);
        check({tag, "_r_valid_after"}, bus.r_valid, 0);
        check({tag, "_clf_rst_n_idle"}, clf_rst_n, 0);
        check({tag, "_total_after"}, total_cnt, m_total);
    endtask

    initial begin
        logic [63:0] rnd;
        logic [2:0]  lab;
        n_chk        = 0;
        n_fail       = 0;
        m_total      = 0;
        m_correct    = 0;
        lat          = 1000;
        cls          = '0;
        rst          = 1'b1;
        clr_cnt      = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_sample = '0;
        bus.s_label  = '0;
        bus.r_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_r_valid", bus.r_valid, 0);
        check("rst_r_class", bus.r_class, 0);
        check("rst_r_label", bus.r_label, 0);
        check("rst_r_match", bus.r_match, 0);
        check("rst_r_timeout", bus.r_timeout, 0);
        check("rst_total", total_cnt, 0);
        check("rst_correct", correct_cnt, 0);
        check("rst_clf_in", clf_in, 0);
        check("rst_clf_rst_n", clf_rst_n, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        run("basic", 44'h123456789AB, 3'd5, 18, 3'd5, 0, 1, 0);
        run("mismatch", 44'h0F0F0F0F0F0, 3'd2, 18, 3'd6, 0, 0, 0);
        run("timeout", 44'h00000000001, 3'd4, 100000, 3'd4, 0, 0, 0);
        run("backpressure", 44'hABCDEF01234, 3'd1, 5, 3'd1, 5, 0, 0);
        run("edge_at_limit", 44'h11111111111, 3'd3, TMO - 1, 3'd3, 0, 0, 0);

        // synchronous reset while the classifier is still running
        lat          = 100000;
        bus.s_valid  = 1'b1;
        bus.s_sample = 44'h55555555555;
        bus.s_label  = 3'd7;
        @(negedge clk);
        bus.s_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("midrun_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_busy_rst", busy, 0);
        check("midrun_clf_rst_n", clf_rst_n, 0);
        check("midrun_r_valid", bus.r_valid, 0);
        check("midrun_total", total_cnt, 0);
        check("midrun_correct", correct_cnt, 0);
        check("midrun_s_ready_rst", bus.s_ready, 0);
        rst       = 1'b0;
        m_total   = 0;
        m_correct = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrun_no_result", bus.r_valid, 0);
            check("midrun_s_ready", bus.s_ready, 1);
        end

        for (int i = 0; i < 9; i++) begin
            rnd = {$urandom, $urandom};
            lab = 3'($urandom_range(0, 7));
            run("sat", rnd[43:0], lab, $urandom_range(1, 12), lab, 0, 0, 0);
        end
        check("sat_total", total_cnt, MAXC);
        check("sat_correct", correct_cnt, MAXC);
        run("clr_capture", 44'h2468ACE1357, 3'd6, 9, 3'd6, 0, 0, 1);
        check("clr_total", total_cnt, 1);
        check("clr_correct", correct_cnt, 1);

        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt   = 1'b0;
        m_total   = 0;
        m_correct = 0;
        check("clr_idle_total", total_cnt, 0);
        check("clr_idle_correct", correct_cnt, 0);

        for (int i = 0; i < 14; i++) begin
            rnd = {$urandom, $urandom};
            lab = 3'($urandom_range(0, 7));
            run("rand", rnd[43:0], lab, $urandom_range(1, 36),
                ($urandom_range(0, 1) == 1) ? lab : 3'($urandom_range(0, 7)),
                $urandom_range(0, 3), 0, ($urandom_range(0, 4) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1, "watchdog expired");
    end
endmodule
